// File: rtl/sync_counter_mod_if.sv
// sync_counter_mod_if: groups the data/control/status signals of one
// sync_counter_mod stage. The master drives load data, load strobe, the two
// count enables and the direction. The slave (the counter) returns the count,
// the ripple carry and the sticky wrap flag.
// WIDTH must match the WIDTH of the counter instance it is bound to.
interface sync_counter_mod_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] d;
  logic             loadN;
  logic             enp;
  logic             ent;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             rco;
  logic             wrap;

  modport master (
    output d, loadN, enp, ent, up,
    input  q, rco, wrap
  );

  modport slave (
    input  d, loadN, enp, ent, up,
    output q, rco, wrap
  );

endinterface

// File: rtl/sync_counter_mod.sv
// sync_counter_mod: parametrised synchronous up/down modulo counter with
// parallel load (clamped to MAX), dual count enables (enp/ent), a
// combinational ripple-carry/borrow output for cascading, and an optional
// sticky wrap flag.
// Priority on each rising edge: clear > load > count > hold.
// Optional feature macro: SYNC_COUNTER_WRAP_FLAG_EN. When it is defined, a
// sticky wrap flag register is built. When it is undefined, wrap is tied low.
module sync_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic                i_clk,
  input  logic                i_clrN,
  sync_counter_mod_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_qNext;
  logic [WIDTH-1:0] w_loadVal;
  logic             w_count;
  logic             w_atMax;
  logic             w_atZero;
  logic             w_atTerminal;
  logic             w_wrapEvent;

  assign w_count      = bus.enp & bus.ent;
  assign w_atMax      = (r_q == MAX);
  assign w_atZero     = (r_q == '0);
  assign w_atTerminal = bus.up ? w_atMax : w_atZero;
  assign w_wrapEvent  = w_count & w_atTerminal;
  assign w_loadVal    = (bus.d > MAX) ? MAX : bus.d;

  // Next count: clear beats load, load beats counting, otherwise hold.
  always_comb begin
    w_qNext = r_q;
    if (!i_clrN) begin
      w_qNext = '0;
    end else if (!bus.loadN) begin
      w_qNext = w_loadVal;
    end else if (w_count) begin
      if (bus.up) begin
        w_qNext = w_atMax ? '0 : r_q + WIDTH'(1);
      end else begin
        w_qNext = w_atZero ? MAX : r_q - WIDTH'(1);
      end
    end
  end

  // Count register; the synchronous clear is folded into w_qNext.
  always_ff @(posedge i_clk) begin
    r_q <= w_qNext;
  end

  assign bus.q   = r_q;
  assign bus.rco = bus.ent & w_atTerminal;

`ifdef SYNC_COUNTER_WRAP_FLAG_EN
  logic r_wrap;

  // Sticky wrap flag: clear or load clears it, which beats a wrap on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_clrN || !bus.loadN) begin
      r_wrap <= 1'b0;
    end else if (w_wrapEvent) begin
      r_wrap <= 1'b1;
    end
  end

  assign bus.wrap = r_wrap;
`else
  assign bus.wrap = 1'b0;
`endif

endmodule

// File: tb/tb_sync_counter_mod.sv
// tb_sync_counter_mod: directed self-checking bench for sync_counter_mod.
// It uses one WIDTH=4, MODULUS=10 instance and a two-stage MODULUS=16 cascade
// (lo.rco -> hi.ent). Expected results come from a reference model and are
// queued when stimulus is applied. They are popped and compared one cycle
// later. The expected wrap value follows SYNC_COUNTER_WRAP_FLAG_EN.
module tb_sync_counter_mod;

`ifdef SYNC_COUNTER_WRAP_FLAG_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    int         which;
    logic [7:0] q;
    logic       rco;
    logic       wrap;
  } expT;

  logic clk;
  logic clrN10;
  logic clrNC;

  expT  scoreQ[$];
  int   total;
  int   bad;

  logic [3:0] m10;
  logic       mWrap10;
  logic [7:0] mC;
  logic       mWrapC;

  sync_counter_mod_if #(.WIDTH(4)) bus10 ();
  sync_counter_mod_if #(.WIDTH(4)) busLo ();
  sync_counter_mod_if #(.WIDTH(4)) busHi ();

  sync_counter_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
    .i_clk  (clk),
    .i_clrN (clrN10),
    .bus    (bus10.slave)
  );

  sync_counter_mod #(.WIDTH(4), .MODULUS(16)) dutLo (
    .i_clk  (clk),
    .i_clrN (clrNC),
    .bus    (busLo.slave)
  );

  sync_counter_mod #(.WIDTH(4), .MODULUS(16)) dutHi (
    .i_clk  (clk),
    .i_clrN (clrNC),
    .bus    (busHi.slave)
  );

  assign busHi.ent = busLo.rco;

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input string tag, input logic clr, input logic load,
                               input logic [3:0] d, input logic enp, input logic ent,
                               input logic up);
    expT e;
    logic [3:0] nq;
    clrN10      = clr;
    bus10.loadN = load;
    bus10.d     = d;
    bus10.enp   = enp;
    bus10.ent   = ent;
    bus10.up    = up;
    nq = m10;
    if (!clr) nq = 4'd0;
    else if (!load) nq = (d > 4'd9) ? 4'd9 : d;
    else if (enp && ent) begin
      if (up) nq = (m10 == 4'd9) ? 4'd0 : m10 + 4'd1;
      else    nq = (m10 == 4'd0) ? 4'd9 : m10 - 4'd1;
    end
    if (!clr || !load) mWrap10 = 1'b0;
    else if (enp && ent && (up ? (m10 == 4'd9) : (m10 == 4'd0))) mWrap10 = 1'b1;
    m10 = nq;
    e.tag   = tag;
    e.which = 0;
    e.q     = {4'd0, nq};
    e.rco   = ent & (up ? (nq == 4'd9) : (nq == 4'd0));
    e.wrap  = WRAP_EN & mWrap10;
    scoreQ.push_back(e);
  endtask

  task automatic applyCascade(input string tag, input logic clr, input logic load,
                              input logic [7:0] d, input logic enp, input logic ent,
                              input logic up);
    expT e;
    logic [7:0] nq;
    clrNC       = clr;
    busLo.loadN = load;
    busHi.loadN = load;
    busLo.d     = d[3:0];
    busHi.d     = d[7:4];
    busLo.enp   = enp;
    busHi.enp   = enp;
    busLo.ent   = ent;
    busLo.up    = up;
    busHi.up    = up;
    nq = mC;
    if (!clr) nq = 8'd0;
    else if (!load) nq = d;
    else if (enp && ent) nq = up ? mC + 8'd1 : mC - 8'd1;
    if (!clr || !load) mWrapC = 1'b0;
    else if (enp && ent && (up ? (mC[3:0] == 4'hF) : (mC[3:0] == 4'h0))) mWrapC = 1'b1;
    mC = nq;
    e.tag   = tag;
    e.which = 1;
    e.q     = nq;
    e.rco   = ent & (up ? (nq == 8'hFF) : (nq == 8'h00));
    e.wrap  = WRAP_EN & mWrapC;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    logic [7:0] obsQ;
    logic       obsRco;
    logic       obsWrap;
    @(posedge clk);
    #1;
    if (scoreQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty: observed size 0 expected >0");
      return;
    end
    e = scoreQ.pop_front();
    if (e.which == 0) begin
      obsQ    = {4'd0, bus10.q};
      obsRco  = bus10.rco;
      obsWrap = bus10.wrap;
    end else begin
      obsQ    = {busHi.q, busLo.q};
      obsRco  = busHi.rco;
      obsWrap = busLo.wrap;
    end
    total++;
    assert (obsQ === e.q) else begin
      bad++;
      $error("[TB] FAIL %s_q: observed %0h expected %0h", e.tag, obsQ, e.q);
    end
    total++;
    assert (obsRco === e.rco) else begin
      bad++;
      $error("[TB] FAIL %s_rco: observed %0b expected %0b", e.tag, obsRco, e.rco);
    end
    total++;
    assert (obsWrap === e.wrap) else begin
      bad++;
      $error("[TB] FAIL %s_wrap: observed %0b expected %0b", e.tag, obsWrap, e.wrap);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m10     = 4'd0;
    mWrap10 = 1'b0;
    mC      = 8'd0;
    mWrapC  = 1'b0;
    clrN10 = 1'b1; bus10.loadN = 1'b1; bus10.d = 4'd0;
    bus10.enp = 1'b0; bus10.ent = 1'b0; bus10.up = 1'b1;
    clrNC = 1'b1; busLo.loadN = 1'b1; busHi.loadN = 1'b1;
    busLo.d = 4'd0; busHi.d = 4'd0; busLo.enp = 1'b0; busHi.enp = 1'b0;
    busLo.ent = 1'b0; busLo.up = 1'b1; busHi.up = 1'b1;
    #2;

    // Initial reset of both groups, then preload 7 into the mod-10 counter.
    applyCascade("rstC", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus("rst", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    begin expT e; e = scoreQ.pop_front(); scoreQ.push_back(e); end
    checkOutput();
    clrNC = 1'b1;
    applyStimulus("load7", 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
    checkOutput();

    // Test 1: reset beats load and count.
    applyStimulus("clrWins", 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
    checkOutput();

    // Test 2: 12 up-counting edges from 0.
    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("up%0d", i), 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
      checkOutput();
    end

    // Test 3: load 0 and count down through the wrap, then toggle direction.
    applyStimulus("load0", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus("down0", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput();
    applyStimulus("down1", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput();
    applyStimulus("dirUp", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyStimulus("dirDown", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput();

    // Test 4: clamp on load, and load beating count while clearing wrap.
    applyStimulus("clamp13", 1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1);
    checkOutput();
    applyStimulus("wrapAgain", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyStimulus("load5", 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1);
    checkOutput();

    // Test 5: hold at 9 with each enable low in turn.
    applyStimulus("load9", 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
    checkOutput();
    applyStimulus("holdEnt", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput();
    applyStimulus("holdEnp", 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    checkOutput();

    // Test 6: cascaded pair counts 0E -> 0F -> 10 -> 11.
    applyCascade("cLoad", 1'b1, 1'b0, 8'h0E, 1'b0, 1'b1, 1'b1);
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyCascade($sformatf("cUp%0d", i), 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
      checkOutput();
    end
    applyCascade("cLoadFF", 1'b1, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1);
    checkOutput();
    applyCascade("cTop", 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyCascade("cWrap", 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
